// File: rtl/axi_noc_pkg.sv
// Shared constants for the AXI NoC read path.
// Slave target codes and AXI response encodings.
package axi_noc_pkg;

   typedef enum logic [2:0] {
      SLV_A   = 3'd0,
      SLV_B   = 3'd1,
      SLV_C   = 3'd2,
      SLV_D   = 3'd3,
      SLV_ERR = 3'd4
   } slv_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/syncfifo.sv
// Show-ahead synchronous FIFO, single clock.
// Push when full and pop when empty are ignored.
module syncfifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_dout  = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/axi_rd_4_splitter.sv
// AXI read 1-to-4 address splitter with in-order R return.
// AXI_RD_SPLIT_DECERR_EN adds a DECERR responder for unmapped slaves.
module axi_rd_4_splitter
   import axi_noc_pkg::*;
#(
   parameter int         IDWID      = 4,
   parameter int         DWID       = 64,
   parameter int         EXTRAS     = 8,
   parameter int         DECODE_LSB = 28,
   parameter int         DEPTH      = 8,
   parameter logic [3:0] SLAVE_MASK = 4'b1111
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDWID-1:0]  m_arid,
   input  logic [31:0]       m_araddr,
   input  logic [7:0]        m_arlen,
   input  logic [EXTRAS-1:0] m_arextras,
   input  logic [1:0]        m_arburst,
   input  logic              m_arvalid,
   output logic              m_arready,
   output logic [IDWID-1:0]  m_rid,
   output logic [DWID-1:0]   m_rdata,
   output logic [1:0]        m_rresp,
   output logic              m_rlast,
   output logic              m_rvalid,
   input  logic              m_rready,
   output logic [IDWID-1:0]  a_arid,
   output logic [31:0]       a_araddr,
   output logic [7:0]        a_arlen,
   output logic [EXTRAS-1:0] a_arextras,
   output logic [1:0]        a_arburst,
   output logic              a_arvalid,
   input  logic              a_arready,
   input  logic [IDWID-1:0]  a_rid,
   input  logic [DWID-1:0]   a_rdata,
   input  logic [1:0]        a_rresp,
   input  logic              a_rlast,
   input  logic              a_rvalid,
   output logic              a_rready,
   output logic [IDWID-1:0]  b_arid,
   output logic [31:0]       b_araddr,
   output logic [7:0]        b_arlen,
   output logic [EXTRAS-1:0] b_arextras,
   output logic [1:0]        b_arburst,
   output logic              b_arvalid,
   input  logic              b_arready,
   input  logic [IDWID-1:0]  b_rid,
   input  logic [DWID-1:0]   b_rdata,
   input  logic [1:0]        b_rresp,
   input  logic              b_rlast,
   input  logic              b_rvalid,
   output logic              b_rready,
   output logic [IDWID-1:0]  c_arid,
   output logic [31:0]       c_araddr,
   output logic [7:0]        c_arlen,
   output logic [EXTRAS-1:0] c_arextras,
   output logic [1:0]        c_arburst,
   output logic              c_arvalid,
   input  logic              c_arready,
   input  logic [IDWID-1:0]  c_rid,
   input  logic [DWID-1:0]   c_rdata,
   input  logic [1:0]        c_rresp,
   input  logic              c_rlast,
   input  logic              c_rvalid,
   output logic              c_rready,
   output logic [IDWID-1:0]  d_arid,
   output logic [31:0]       d_araddr,
   output logic [7:0]        d_arlen,
   output logic [EXTRAS-1:0] d_arextras,
   output logic [1:0]        d_arburst,
   output logic              d_arvalid,
   input  logic              d_arready,
   input  logic [IDWID-1:0]  d_rid,
   input  logic [DWID-1:0]   d_rdata,
   input  logic [1:0]        d_rresp,
   input  logic              d_rlast,
   input  logic              d_rvalid,
   output logic              d_rready
);

   localparam int FW = 3 + IDWID + 8;

   logic [1:0]       w_sel;
   logic             w_mapped;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [2:0]       w_push_tgt;
   logic [FW-1:0]    w_head;
   logic [2:0]       w_head_tgt;
   logic [IDWID-1:0] w_head_id;
   logic [7:0]       w_head_len;
   logic [3:0]       w_arready;
   logic [3:0]       w_arvalid;
   logic [3:0]       w_rvalid;
   logic [3:0]       w_rlast;
   logic [3:0]       w_rready;
   logic [IDWID-1:0] w_rid   [4];
   logic [DWID-1:0]  w_rdata [4];
   logic [1:0]       w_rresp [4];

   assign w_sel = m_araddr[DECODE_LSB+1:DECODE_LSB];

`ifdef AXI_RD_SPLIT_DECERR_EN
   assign w_mapped = SLAVE_MASK[w_sel];
`else
   logic w_unused;
   assign w_mapped = 1'b1;
   assign w_unused = ^{SLAVE_MASK, w_head_id, w_head_len};
`endif

   assign w_arready = {d_arready, c_arready, b_arready, a_arready};
   assign m_arready = !w_full &&
                      (w_mapped ? w_arready[w_sel] : 1'b1);

   always_comb begin
      w_arvalid        = '0;
      w_arvalid[w_sel] = m_arvalid && w_mapped && !w_full;
   end

   assign a_arvalid = w_arvalid[0];
   assign b_arvalid = w_arvalid[1];
   assign c_arvalid = w_arvalid[2];
   assign d_arvalid = w_arvalid[3];

   assign a_arid = m_arid;
   assign b_arid = m_arid;
   assign c_arid = m_arid;
   assign d_arid = m_arid;
   assign a_araddr = m_araddr;
   assign b_araddr = m_araddr;
   assign c_araddr = m_araddr;
   assign d_araddr = m_araddr;
   assign a_arlen = m_arlen;
   assign b_arlen = m_arlen;
   assign c_arlen = m_arlen;
   assign d_arlen = m_arlen;
   assign a_arextras = m_arextras;
   assign b_arextras = m_arextras;
   assign c_arextras = m_arextras;
   assign d_arextras = m_arextras;
   assign a_arburst = m_arburst;
   assign b_arburst = m_arburst;
   assign c_arburst = m_arburst;
   assign d_arburst = m_arburst;

   assign w_push     = m_arvalid && m_arready;
   assign w_push_tgt = w_mapped ? {1'b0, w_sel} : SLV_ERR;

   // Routing FIFO: one entry per outstanding burst, AR order.
   syncfifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_ord (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_din   ({w_push_tgt, m_arid, m_arlen}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign {w_head_tgt, w_head_id, w_head_len} = w_head;

   assign w_rvalid = {d_rvalid, c_rvalid, b_rvalid, a_rvalid};
   assign w_rlast  = {d_rlast, c_rlast, b_rlast, a_rlast};
   assign w_rid    = '{a_rid, b_rid, c_rid, d_rid};
   assign w_rdata  = '{a_rdata, b_rdata, c_rdata, d_rdata};
   assign w_rresp  = '{a_rresp, b_rresp, c_rresp, d_rresp};

`ifdef AXI_RD_SPLIT_DECERR_EN
   logic [7:0] r_beat;
   logic       w_is_err;

   assign w_is_err = !w_empty && (w_head_tgt == SLV_ERR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat <= '0;
      end else if (w_is_err && m_rready) begin
         r_beat <= m_rlast ? 8'd0 : r_beat + 8'd1;
      end
   end
`endif

   always_comb begin
      m_rvalid = 1'b0;
      m_rid    = '0;
      m_rdata  = '0;
      m_rresp  = RESP_OKAY;
      m_rlast  = 1'b0;
      unique case (1'b1)
         w_empty: begin
         end
`ifdef AXI_RD_SPLIT_DECERR_EN
         w_is_err: begin
            m_rvalid = 1'b1;
            m_rid    = w_head_id;
            m_rresp  = RESP_DECERR;
            m_rlast  = (r_beat == w_head_len);
         end
`endif
         default: begin
            m_rvalid = w_rvalid[w_head_tgt[1:0]];
            m_rid    = w_rid[w_head_tgt[1:0]];
            m_rdata  = w_rdata[w_head_tgt[1:0]];
            m_rresp  = w_rresp[w_head_tgt[1:0]];
            m_rlast  = w_rlast[w_head_tgt[1:0]];
         end
      endcase
   end

   // Only the head slave sees rready; others stall.
   always_comb begin
      w_rready = '0;
      w_rready[w_head_tgt[1:0]] =
         m_rready && !w_empty && !w_head_tgt[2];
   end

   assign a_rready = w_rready[0];
   assign b_rready = w_rready[1];
   assign c_rready = w_rready[2];
   assign d_rready = w_rready[3];

   assign w_pop = m_rvalid && m_rready && m_rlast;

endmodule

// File: tb/tb_axi_rd_4_splitter.sv
// Self-checking bench for axi_rd_4_splitter.
// Directed scenarios plus a randomized run against an order model.
module tb_axi_rd_4_splitter;

   localparam int DEPTH = 8;
`ifdef AXI_RD_SPLIT_DECERR_EN
   localparam logic [3:0] MASK = 4'b0111;
`else
   localparam logic [3:0] MASK = 4'b1111;
`endif

   typedef struct {
      int slv;
      int id;
      int len;
      int seq;
   } burst_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  m_arid;
   logic [31:0] m_araddr;
   logic [7:0]  m_arlen;
   logic [7:0]  m_arextras;
   logic [1:0]  m_arburst;
   logic        m_arvalid;
   logic        m_arready;
   logic [3:0]  m_rid;
   logic [63:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rlast;
   logic        m_rvalid;
   logic        m_rready;

   logic [3:0]  s_arid     [4];
   logic [31:0] s_araddr   [4];
   logic [7:0]  s_arlen    [4];
   logic [7:0]  s_arextras [4];
   logic [1:0]  s_arburst  [4];
   logic [3:0]  s_arvalid;
   logic [3:0]  s_arready;
   logic [3:0]  s_rid      [4];
   logic [63:0] s_rdata    [4];
   logic [1:0]  s_rresp    [4];
   logic [3:0]  s_rlast;
   logic [3:0]  s_rvalid;
   logic [3:0]  s_rready;

   int checks;
   int failures;

   burst_t exp_q [$];
   burst_t sq    [4][$];
   int     slv_seq [4];
   int     sbeat   [4];
   int     mseq    [4];

   axi_rd_4_splitter #(
      .IDWID      (4),
      .DWID       (64),
      .EXTRAS     (8),
      .DECODE_LSB (28),
      .DEPTH      (DEPTH),
      .SLAVE_MASK (MASK)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m_arid(m_arid), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arextras(m_arextras),
      .m_arburst(m_arburst), .m_arvalid(m_arvalid),
      .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_rlast(m_rlast), .m_rvalid(m_rvalid),
      .m_rready(m_rready),
      .a_arid(s_arid[0]), .a_araddr(s_araddr[0]),
      .a_arlen(s_arlen[0]), .a_arextras(s_arextras[0]),
      .a_arburst(s_arburst[0]), .a_arvalid(s_arvalid[0]),
      .a_arready(s_arready[0]),
      .a_rid(s_rid[0]), .a_rdata(s_rdata[0]),
      .a_rresp(s_rresp[0]), .a_rlast(s_rlast[0]),
      .a_rvalid(s_rvalid[0]), .a_rready(s_rready[0]),
      .b_arid(s_arid[1]), .b_araddr(s_araddr[1]),
      .b_arlen(s_arlen[1]), .b_arextras(s_arextras[1]),
      .b_arburst(s_arburst[1]), .b_arvalid(s_arvalid[1]),
      .b_arready(s_arready[1]),
      .b_rid(s_rid[1]), .b_rdata(s_rdata[1]),
      .b_rresp(s_rresp[1]), .b_rlast(s_rlast[1]),
      .b_rvalid(s_rvalid[1]), .b_rready(s_rready[1]),
      .c_arid(s_arid[2]), .c_araddr(s_araddr[2]),
      .c_arlen(s_arlen[2]), .c_arextras(s_arextras[2]),
      .c_arburst(s_arburst[2]), .c_arvalid(s_arvalid[2]),
      .c_arready(s_arready[2]),
      .c_rid(s_rid[2]), .c_rdata(s_rdata[2]),
      .c_rresp(s_rresp[2]), .c_rlast(s_rlast[2]),
      .c_rvalid(s_rvalid[2]), .c_rready(s_rready[2]),
      .d_arid(s_arid[3]), .d_araddr(s_araddr[3]),
      .d_arlen(s_arlen[3]), .d_arextras(s_arextras[3]),
      .d_arburst(s_arburst[3]), .d_arvalid(s_arvalid[3]),
      .d_arready(s_arready[3]),
      .d_rid(s_rid[3]), .d_rdata(s_rdata[3]),
      .d_rresp(s_rresp[3]), .d_rlast(s_rlast[3]),
      .d_rvalid(s_rvalid[3]), .d_rready(s_rready[3])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] mkdata(int s, int q, int bt);
      return {8'(s), 24'(q), 16'(bt), 16'hA5A5};
   endfunction

   function automatic logic [1:0] mkresp(int s, int bt);
      return 2'(s ^ bt);
   endfunction

   function automatic bit mapped(int s);
      return MASK[s];
   endfunction

   task automatic set_r(int s, int id, logic [63:0] d, bit last);
      s_rvalid[s] = 1'b1;
      s_rid[s]    = 4'(id);
      s_rdata[s]  = d;
      s_rresp[s]  = 2'b00;
      s_rlast[s]  = last;
   endtask

   task automatic send_ar(logic [31:0] addr, int id, int len);
      m_araddr   = addr;
      m_arid     = 4'(id);
      m_arlen    = 8'(len);
      m_arextras = 8'h5A;
      m_arburst  = 2'b01;
      m_arvalid  = 1'b1;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      m_arvalid = 1'b0; m_rready = 1'b0;
      m_araddr = '0; m_arid = '0; m_arlen = '0;
      m_arextras = '0; m_arburst = '0;
      s_arready = '0; s_rvalid = '0; s_rlast = '0;
      for (int s = 0; s < 4; s++) begin
         s_rid[s] = '0; s_rdata[s] = '0; s_rresp[s] = '0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      s_arready = 4'hF; s_rvalid = 4'hF; s_rlast = 4'hF;
      for (int s = 0; s < 4; s++) s_rdata[s] = 64'hDEAD;
      m_rready = 1'b1; m_arvalid = 1'b0;
      #1;
      checks++;
      if ({m_rvalid, s_rready, s_arvalid} !== 9'b0) begin
         failures++;
         $display("FAIL rst_valid got rv=%b rr=%b av=%b req 0",
                  m_rvalid, s_rready, s_arvalid);
      end
      checks++;
      if ({m_rid, m_rdata, m_rresp, m_rlast} !== 71'b0) begin
         failures++;
         $display("FAIL rst_rfields got id=%h d=%h r=%b l=%b req 0",
                  m_rid, m_rdata, m_rresp, m_rlast);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({m_rvalid, s_rready, s_arvalid} !== 9'b0) begin
         failures++;
         $display("FAIL rst_after got rv=%b rr=%b av=%b req 0",
                  m_rvalid, s_rready, s_arvalid);
      end
   endtask

   task automatic test_single_c();
      reset_dut();
      s_arready = 4'hF;
      @(negedge clk);
      send_ar(32'h2000_0000, 5, 3);
      #1;
      checks++;
      if ({s_arvalid, m_arready} !== 5'b0100_1) begin
         failures++;
         $display("FAIL c_ar got av=%b ar=%b req 0100/1",
                  s_arvalid, m_arready);
      end
      @(negedge clk);
      m_arvalid = 1'b0;
      m_rready = 1'b1;
      for (int bt = 0; bt < 4; bt++) begin
         if (bt > 0) @(negedge clk);
         set_r(2, 5, 64'hC0DE_0000 + 64'(bt), bt == 3);
         #1;
         checks++;
         if ({m_rvalid, m_rid, m_rdata, m_rlast, s_rready, s_arvalid}
             !== {1'b1, 4'd5, 64'hC0DE_0000 + 64'(bt), bt == 3,
                  4'b0100, 4'b0000}) begin
            failures++;
            $display("FAIL c_beat%0d got v=%b id=%0d d=%h l=%b rr=%b",
                     bt, m_rvalid, m_rid, m_rdata, m_rlast, s_rready);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if ({m_rvalid, s_rready} !== 5'b0) begin
         failures++;
         $display("FAIL c_empty got rv=%b rr=%b req 0",
                  m_rvalid, s_rready);
      end
   endtask

   task automatic test_order();
      reset_dut();
      s_arready = 4'hF;
      @(negedge clk);
      send_ar(32'h1000_0000, 1, 1);
      @(negedge clk);
      send_ar(32'h0000_0000, 2, 0);
      @(negedge clk);
      m_arvalid = 1'b0;
      m_rready = 1'b1;
      set_r(0, 2, 64'hAAAA, 1'b1);
      for (int k = 0; k < 2; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checks++;
         if ({m_rvalid, s_rready} !== 5'b0_0010) begin
            failures++;
            $display("FAIL ord_wait got rv=%b rr=%b req 0/0010",
                     m_rvalid, s_rready);
         end
      end
      for (int bt = 0; bt < 2; bt++) begin
         @(negedge clk);
         set_r(1, 1, 64'hBB00 + 64'(bt), bt == 1);
         #1;
         checks++;
         if ({s_rready, m_rdata, m_rlast, m_rid}
             !== {4'b0010, 64'hBB00 + 64'(bt), bt == 1, 4'd1}) begin
            failures++;
            $display("FAIL ord_b%0d got rr=%b d=%h l=%b id=%0d",
                     bt, s_rready, m_rdata, m_rlast, m_rid);
         end
      end
      @(negedge clk);
      s_rvalid[1] = 1'b0;
      #1;
      checks++;
      if ({s_rready, m_rvalid, m_rdata, m_rlast, m_rid}
          !== {4'b0001, 1'b1, 64'hAAAA, 1'b1, 4'd2}) begin
         failures++;
         $display("FAIL ord_a got rr=%b v=%b d=%h l=%b id=%0d",
                  s_rready, m_rvalid, m_rdata, m_rlast, m_rid);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({m_rvalid, s_rready} !== 5'b0) begin
         failures++;
         $display("FAIL ord_empty got rv=%b rr=%b req 0",
                  m_rvalid, s_rready);
      end
   endtask

   task automatic test_full();
      int eid;
      reset_dut();
      s_arready = 4'hF;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         send_ar(32'h3000_0000, k, 0);
         #1;
         checks++;
         if (m_arready !== mapped(3) || m_arready !== 1'b1) begin
            failures++;
            $display("FAIL full_fill%0d got ar=%b req 1", k, m_arready);
         end
      end
      @(negedge clk);
      send_ar(32'h3000_0000, 9, 0);
      #1;
      checks++;
      if ({m_arready, s_arvalid} !== 5'b0) begin
         failures++;
         $display("FAIL full_block got ar=%b av=%b req 0/0000",
                  m_arready, s_arvalid);
      end
      @(negedge clk);
      m_rready = 1'b1;
      set_r(3, 0, 64'h0, 1'b1);
      #1;
      checks++;
      if ({m_arready, m_rvalid, m_rid} !== {1'b0, 1'b1, 4'd0}) begin
         failures++;
         $display("FAIL full_popcyc got ar=%b rv=%b id=%0d req 0/1/0",
                  m_arready, m_rvalid, m_rid);
      end
      @(negedge clk);
      s_rvalid[3] = 1'b0;
      #1;
      checks++;
      if ({m_arready, s_arvalid} !== 5'b1_1000) begin
         failures++;
         $display("FAIL full_reopen got ar=%b av=%b req 1/1000",
                  m_arready, s_arvalid);
      end
      @(negedge clk);
      m_arvalid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         eid = (k < 7) ? k + 1 : 9;
         set_r(3, eid, 64'(k), 1'b1);
         #1;
         checks++;
         if ({m_rvalid, m_rid, s_rready} !== {1'b1, 4'(eid), 4'b1000})
         begin
            failures++;
            $display("FAIL full_drain%0d got v=%b id=%0d rr=%b req id=%0d",
                     k, m_rvalid, m_rid, s_rready, eid);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if ({m_rvalid, s_rready} !== 5'b0) begin
         failures++;
         $display("FAIL full_empty got rv=%b rr=%b req 0",
                  m_rvalid, s_rready);
      end
   endtask

   task automatic test_backpressure();
      reset_dut();
      s_arready = 4'hF;
      @(negedge clk);
      send_ar(32'h1000_0000, 3, 3);
      @(negedge clk);
      m_arvalid = 1'b0;
      m_rready = 1'b0;
      set_r(1, 3, 64'hB000, 1'b0);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checks++;
         if ({s_rready, m_rvalid, m_rdata}
             !== {4'b0000, 1'b1, 64'hB000}) begin
            failures++;
            $display("FAIL bp_hold%0d got rr=%b v=%b d=%h req 0/1/b000",
                     k, s_rready, m_rvalid, m_rdata);
         end
      end
      for (int bt = 0; bt < 4; bt++) begin
         if (bt > 0) @(negedge clk);
         m_rready = 1'b1;
         set_r(1, 3, 64'hB000 + 64'(bt), bt == 3);
         #1;
         checks++;
         if ({s_rready, m_rvalid, m_rdata, m_rlast}
             !== {4'b0010, 1'b1, 64'hB000 + 64'(bt), bt == 3}) begin
            failures++;
            $display("FAIL bp_beat%0d got rr=%b v=%b d=%h l=%b",
                     bt, s_rready, m_rvalid, m_rdata, m_rlast);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (m_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL bp_empty got rv=%b req 0", m_rvalid);
      end
   endtask

   task automatic test_reset_mid();
      reset_dut();
      s_arready = 4'hF;
      @(negedge clk);
      send_ar(32'h0000_0000, 4, 3);
      @(negedge clk);
      m_arvalid = 1'b0;
      m_rready = 1'b1;
      set_r(0, 4, 64'h1, 1'b0);
      @(negedge clk);
      set_r(0, 4, 64'h2, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({m_rvalid, s_rready} !== 5'b0) begin
         failures++;
         $display("FAIL rstmid got rv=%b rr=%b req 0", m_rvalid, s_rready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      s_rvalid = '0;
      send_ar(32'h2000_0000, 6, 0);
      #1;
      checks++;
      if ({s_arvalid, m_arready} !== 5'b0100_1) begin
         failures++;
         $display("FAIL rstmid_ar got av=%b ar=%b req 0100/1",
                  s_arvalid, m_arready);
      end
      @(negedge clk);
      m_arvalid = 1'b0;
      set_r(2, 6, 64'h66, 1'b1);
      #1;
      checks++;
      if ({m_rvalid, m_rid, m_rlast, m_rdata, s_rready}
          !== {1'b1, 4'd6, 1'b1, 64'h66, 4'b0100}) begin
         failures++;
         $display("FAIL rstmid_r got v=%b id=%0d l=%b d=%h rr=%b",
                  m_rvalid, m_rid, m_rlast, m_rdata, s_rready);
      end
   endtask

`ifdef AXI_RD_SPLIT_DECERR_EN
   task automatic test_decerr();
      reset_dut();
      s_arready = 4'h0;
      @(negedge clk);
      send_ar(32'h3000_0000, 7, 1);
      #1;
      checks++;
      if ({s_arvalid, m_arready} !== 5'b0000_1) begin
         failures++;
         $display("FAIL de_ar got av=%b ar=%b req 0000/1",
                  s_arvalid, m_arready);
      end
      @(negedge clk);
      m_arvalid = 1'b0;
      m_rready = 1'b0;
      #1;
      checks++;
      if ({m_rvalid, m_rid, m_rresp, m_rlast, m_rdata}
          !== {1'b1, 4'd7, 2'b11, 1'b0, 64'h0}) begin
         failures++;
         $display("FAIL de_hold got v=%b id=%0d r=%b l=%b d=%h",
                  m_rvalid, m_rid, m_rresp, m_rlast, m_rdata);
      end
      for (int bt = 0; bt < 2; bt++) begin
         @(negedge clk);
         m_rready = 1'b1;
         #1;
         checks++;
         if ({m_rvalid, m_rid, m_rresp, m_rlast, m_rdata, s_rready}
             !== {1'b1, 4'd7, 2'b11, bt == 1, 64'h0, 4'b0}) begin
            failures++;
            $display("FAIL de_beat%0d got v=%b id=%0d r=%b l=%b rr=%b",
                     bt, m_rvalid, m_rid, m_rresp, m_rlast, s_rready);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (m_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL de_empty got rv=%b req 0", m_rvalid);
      end
   endtask
`endif

   task automatic test_random();
      int n, head, sel, mbeat, eslv, elen, eid, eseq;
      bit full, map, exp_rv, exp_ar, ar_clr;
      logic [3:0] exp_vec, s_done;
      logic [63:0] edata;
      logic [1:0] eresp;
      burst_t b;
      reset_dut();
      exp_q.delete();
      for (int s = 0; s < 4; s++) begin
         sq[s].delete();
         slv_seq[s] = 0; sbeat[s] = 0; mseq[s] = 0;
      end
      mbeat = 0; s_done = '0; ar_clr = 1'b0;
      for (int cyc = 0; cyc < 2500; cyc++) begin
         @(negedge clk);
         if (ar_clr) m_arvalid = 1'b0;
         ar_clr = 1'b0;
         if (!m_arvalid && cyc < 2000 && $urandom_range(0, 2) != 0) begin
            m_araddr   = $urandom;
            m_arid     = 4'($urandom);
            m_arlen    = 8'($urandom_range(0, 3));
            m_arextras = 8'($urandom);
            m_arburst  = 2'($urandom);
            m_arvalid  = 1'b1;
         end
         s_arready = 4'($urandom);
         for (int s = 0; s < 4; s++) begin
            if (s_done[s]) s_rvalid[s] = 1'b0;
            if (!s_rvalid[s] && sq[s].size() > 0 &&
                $urandom_range(0, 1) == 1) begin
               b = sq[s][0];
               s_rvalid[s] = 1'b1;
               s_rid[s]    = 4'(b.id);
               s_rdata[s]  = mkdata(s, b.seq, sbeat[s]);
               s_rresp[s]  = mkresp(s, sbeat[s]);
               s_rlast[s]  = (sbeat[s] == b.len);
            end
         end
         s_done = '0;
         m_rready = ($urandom_range(0, 3) != 0);
         #1;
         sel = int'(m_araddr[29:28]);
         map = mapped(sel);
         n = exp_q.size();
         full = (n >= DEPTH);
         exp_vec = (m_arvalid && map && !full) ? 4'(1 << sel) : 4'b0;
         checks++;
         if (s_arvalid !== exp_vec) begin
            failures++;
            $display("FAIL rnd_arvalid cyc=%0d got=%b req=%b",
                     cyc, s_arvalid, exp_vec);
         end
         exp_ar = !full && (map ? s_arready[sel] : 1'b1);
         checks++;
         if (m_arready !== exp_ar) begin
            failures++;
            $display("FAIL rnd_arready cyc=%0d got=%b req=%b",
                     cyc, m_arready, exp_ar);
         end
         for (int s = 0; s < 4; s++) begin
            checks++;
            if ({s_arid[s], s_araddr[s], s_arlen[s], s_arextras[s],
                 s_arburst[s]} !== {m_arid, m_araddr, m_arlen,
                 m_arextras, m_arburst}) begin
               failures++;
               $display("FAIL rnd_arfields cyc=%0d slv=%0d got=%h req=%h",
                        cyc, s, s_araddr[s], m_araddr);
            end
         end
         head = (n > 0) ? exp_q[0].slv : -1;
         exp_vec = (m_rready && n > 0 && head < 4) ?
                   4'(1 << head) : 4'b0;
         checks++;
         if (s_rready !== exp_vec) begin
            failures++;
            $display("FAIL rnd_rready cyc=%0d got=%b req=%b",
                     cyc, s_rready, exp_vec);
         end
         exp_rv = (n == 0) ? 1'b0 : (head == 4) ? 1'b1 : s_rvalid[head];
         checks++;
         if (m_rvalid !== exp_rv) begin
            failures++;
            $display("FAIL rnd_rvalid cyc=%0d got=%b req=%b",
                     cyc, m_rvalid, exp_rv);
         end
         if (n == 0) begin
            checks++;
            if ({m_rid, m_rdata, m_rresp, m_rlast} !== 71'b0) begin
               failures++;
               $display("FAIL rnd_idle cyc=%0d got d=%h req 0",
                        cyc, m_rdata);
            end
         end else if (exp_rv) begin
            eid = exp_q[0].id;
            elen = exp_q[0].len;
            if (head == 4) begin
               edata = '0;
               eresp = 2'b11;
            end else begin
               edata = mkdata(head, exp_q[0].seq, mbeat);
               eresp = mkresp(head, mbeat);
            end
            checks++;
            if ({m_rid, m_rdata, m_rresp, m_rlast} !==
                {4'(eid), edata, eresp, mbeat == elen}) begin
               failures++;
               $display("FAIL rnd_rbeat cyc=%0d got id=%0d d=%h r=%b l=%b req id=%0d d=%h r=%b l=%b",
                        cyc, m_rid, m_rdata, m_rresp, m_rlast,
                        eid, edata, eresp, mbeat == elen);
            end
         end
         if (m_arvalid && exp_ar) begin
            eslv = map ? sel : 4;
            eseq = 0;
            if (map) begin
               eseq = mseq[sel];
               mseq[sel]++;
            end
            exp_q.push_back('{eslv, int'(m_arid), int'(m_arlen), eseq});
            ar_clr = 1'b1;
         end
         if (exp_rv && m_rready) begin
            if (mbeat == exp_q[0].len) begin
               void'(exp_q.pop_front());
               mbeat = 0;
            end else begin
               mbeat++;
            end
         end
         for (int s = 0; s < 4; s++) begin
            if (s_arvalid[s] && s_arready[s]) begin
               sq[s].push_back('{s, int'(s_arid[s]), int'(s_arlen[s]),
                                slv_seq[s]});
               slv_seq[s]++;
            end
            if (s_rvalid[s] && s_rready[s] && sq[s].size() > 0) begin
               s_done[s] = 1'b1;
               if (sbeat[s] == sq[s][0].len) begin
                  void'(sq[s].pop_front());
                  sbeat[s] = 0;
               end else begin
                  sbeat[s]++;
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL rnd_drain got outstanding=%0d req 0",
                  exp_q.size());
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      m_arvalid = 1'b0; m_rready = 1'b0;
      s_arready = '0; s_rvalid = '0; s_rlast = '0;
      test_reset();
      test_single_c();
      test_order();
      test_full();
      test_backpressure();
      test_reset_mid();
`ifdef AXI_RD_SPLIT_DECERR_EN
      test_decerr();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_rd_4_splitter.md
Name: axi_rd_4_splitter

Overview:
- AXI read-channel 1-to-4 address splitter; sits directly downstream of the 4-master read merger.
- Routes each AR from the single master port to one of four slave ports, decoded from two address bits.
- Returns R bursts to the master strictly in AR-acceptance order, tracked by an in-order routing FIFO.

Parameters:
IDWID, 4, AR/R id width
DWID, 64, read data width
EXTRAS, 8, sideband bits carried with AR
DECODE_LSB, 28, LSB of 2-bit slave-select field araddr[DECODE_LSB+1:DECODE_LSB]
DEPTH, 8, outstanding-burst capacity of routing FIFO (power of 2)
SLAVE_MASK, 4'b1111, bit x=1 means slave x is mapped (used only with DECERR feature)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
m_arid  in  IDWID  master AR id
m_araddr  in  32  master AR address
m_arlen  in  8  beats-1
m_arextras  in  EXTRAS  sideband
m_arburst  in  2  burst type
m_arvalid  in  1  AR valid
m_arready  out  1  AR ready
m_rid  out  IDWID  R id
m_rdata  out  DWID  R data
m_rresp  out  2  R response
m_rlast  out  1  last beat
m_rvalid  out  1  R valid
m_rready  in  1  R ready
x_arid/x_araddr/x_arlen/x_arextras/x_arburst  out  as master  x in {a,b,c,d}; copy of m_ar* fields
x_arvalid  out  1  AR valid to slave x
x_arready  in  1  AR ready from slave x
x_rid/x_rdata/x_rresp/x_rlast  in  as master  R fields from slave x
x_rvalid  in  1  R valid from slave x
x_rready  out  1  R ready to slave x

Behaviour:
- sel = m_araddr[DECODE_LSB+1:DECODE_LSB]; a=0, b=1, c=2, d=3.
- AR path, zero latency, combinational:
  - x_arvalid = m_arvalid && sel==x && !ord_full.
  - m_arready = x_arready[sel] && !ord_full.
  - x_ar* fields are always driven with m_ar* (not gated).
- AR handshake (m_arvalid && m_arready) pushes {tgt[2:0]=sel, m_arid, m_arlen} into the routing FIFO.
- When the FIFO is full, m_arready=0 even if a pop occurs in the same cycle.
- R path, combinational from FIFO head tgt:
  - m_r* = tgt slave r*.
  - x_rready = m_rready && !ord_empty && tgt==x.
  - Non-head slaves are back-pressured (x_rready=0).
  - FIFO empty: m_rvalid=0, m_rid/m_rdata/m_rresp/m_rlast=0.
- Pop on m_rvalid && m_rready && m_rlast. Push and pop in the same cycle are both honoured; count is unchanged.
- A slave's rid is passed through unchanged; it is not checked against the stored id.
- Reset: FIFO empty, beat counter 0. Hence m_rvalid=0 and all x_rready=0; x_arvalid=0 until m_arvalid. A reset mid-burst discards all outstanding routing.

Optional Feature:
AXI_RD_SPLIT_DECERR_EN
- Defined: AR with SLAVE_MASK[sel]==0 drives no x_arvalid and is accepted internally (m_arready=!ord_full); push tgt=4.
- When head tgt==4, an internal responder drives:
  - m_rvalid=1, m_rid=stored id, m_rdata=0, m_rresp=2'b11.
  - m_rlast when 8-bit beat counter==stored arlen.
  - Counter increments per handshake and clears on the last beat.
- Undefined: SLAVE_MASK is ignored, every sel is mapped, tgt fits 2 bits, and there is no responder logic.

Decomposition:
- Package axi_noc_pkg: slave index constants (SLV_A..SLV_D, SLV_ERR=4), RESP_OKAY=2'b00, RESP_DECERR=2'b11.
- Sub-module: the existing syncfifo is instantiated as the routing FIFO (width 3+IDWID+8, depth DEPTH); there is no new sub-module.

Test Plan:
- AR araddr=0x2000_0000, arid=5, arlen=3; slave c returns 4 beats -> c_arvalid pulse; m_r* shows c data, m_rlast on beat 4, FIFO empty afterwards.
- AR to b (0x1000_0000) then a (0x0000_0000); a responds first -> a_rready=0 until b's rlast handshake completes; then a's burst passes through.
- 8 ARs to d with no R returned -> 9th AR sees m_arready=0; one d rlast pop -> m_arready=1 next cycle.
- m_rready held low while b_rvalid=1 -> b_rready=0 and data held; release -> beats transfer one per cycle.
- With DECERR_EN, SLAVE_MASK=4'b0111: AR 0x3000_0000, arid=7, arlen=1 -> no d_arvalid; 2 beats with rid=7, rresp=2'b11, rlast on beat 2.
- Assert rst_n mid-burst -> m_rvalid=0 and all x_rready=0 immediately; next AR routes normally.
